// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator: each channel runs a
// Bresenham accumulator that emits NUM pulses per DEN refclk cycles.
module clk_en_gen #(
    parameter int                     NCH      = 4,
    parameter int                     ACC_W    = 24,
    parameter int                     SEL_W    = 2,
    parameter logic [NCH*ACC_W-1:0]   DEF_NUM  = {NCH{24'd1}},
    parameter logic [NCH*ACC_W-1:0]   DEF_DEN  = {NCH{24'd6}},
    parameter int                     LOCK_CYC = 16
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [ACC_W-1:0] cfg_num,
    input  logic [ACC_W-1:0] cfg_den,
    input  logic [NCH-1:0]   ch_run,
    output logic [NCH-1:0]   ce,
    output logic             locked
);

    localparam int          CNT_W = $clog2(LOCK_CYC + 1);
    localparam logic [31:0] NCH_U = 32'(NCH);

    // Config port: cfg_we is a single-cycle strobe with no back-pressure;
    // a write whose cfg_sel names no channel is dropped and leaves lock alone.
    logic wr_valid;
    assign wr_valid = cfg_we && (32'(cfg_sel) < NCH_U);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [ACC_W-1:0] num_q, num_d;
        logic [ACC_W-1:0] den_q, den_d;
        logic [ACC_W-1:0] acc_q, acc_d;
        logic [ACC_W-1:0] n_eff;
        logic [ACC_W:0]   sum;
        logic             ce_q, ce_d;
        logic             wr_hit;

        assign wr_hit = wr_valid && (32'(cfg_sel) == 32'(g));
        // Clamping n to den makes num >= den degenerate to a constant-high enable.
        assign n_eff  = (num_q < den_q) ? num_q : den_q;
        assign sum    = {1'b0, acc_q} + {1'b0, n_eff};

        always_comb begin
            num_d = num_q;
            den_d = den_q;
            acc_d = acc_q;
            ce_d  = 1'b0;
            if (wr_hit) begin
                num_d = cfg_num;
                den_d = cfg_den;
                acc_d = '0;
            end else if (!ch_run[g] || (den_q == '0)) begin
                acc_d = '0;
            end else if (sum >= {1'b0, den_q}) begin
                acc_d = ACC_W'(sum - {1'b0, den_q});
                ce_d  = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end

        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                num_q <= DEF_NUM[g*ACC_W +: ACC_W];
                den_q <= DEF_DEN[g*ACC_W +: ACC_W];
                acc_q <= '0;
                ce_q  <= 1'b0;
            end else begin
                num_q <= num_d;
                den_q <= den_d;
                acc_q <= acc_d;
                ce_q  <= ce_d;
            end
        end

        assign ce[g] = ce_q;
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             locked_q, locked_d;

    always_comb begin
        cnt_d    = cnt_q;
        locked_d = 1'b0;
        if (wr_valid) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(LOCK_CYC)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        locked_d = (cnt_d == CNT_W'(LOCK_CYC));
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: the driver queues the expected {locked, ce}
// per edge, and a monitor compares it just after each rising edge.
module tb_clk_en_gen;
  localparam int NCH   = 4;
  localparam int ACC_W = 24;
  localparam int SEL_W = 3;

  logic             refclk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [SEL_W-1:0] cfg_sel;
  logic [ACC_W-1:0] cfg_num;
  logic [ACC_W-1:0] cfg_den;
  logic [NCH-1:0]   ch_run;
  logic [NCH-1:0]   ce;
  logic             locked;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;
  int last_wr = 0;
  int j1      = 0;
  int cnt     = 0;
  int adj     = 0;
  logic prev;

  // entry = {mask[4:0], value[4:0]} over {locked, ce[3:0]}
  logic [9:0] exp_q[$];

  always #5 refclk = ~refclk;

  clk_en_gen #(
    .NCH(NCH), .ACC_W(ACC_W), .SEL_W(SEL_W)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .cfg_we (cfg_we),
    .cfg_sel(cfg_sel),
    .cfg_num(cfg_num),
    .cfg_den(cfg_den),
    .ch_run (ch_run),
    .ce     (ce),
    .locked (locked)
  );

  // monitor / scoreboard
  always begin
    logic [9:0] ent;
    @(posedge refclk);
    #1;
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      n_tests++;
      if (({locked, ce} & ent[9:5]) !== (ent[4:0] & ent[9:5])) begin
        n_fail++;
        $display("FAIL edge_%0d: locked/ce got %b required %b (mask %b)",
                 ecnt, {locked, ce}, ent[4:0], ent[9:5]);
      end
    end
  end

  function automatic logic ce0_nx();
    return ((ecnt + 1) % 6) == 0;
  endfunction

  function automatic logic p25(input int j);
    return ((j % 5) == 3) || ((j % 5) == 0);
  endfunction

  // One refclk edge: queue the expectation, wait for the edge, drop the strobe.
  task automatic cyc(input logic [3:0] e_ce, input logic [3:0] m_ce, input bit wr);
    logic lk;
    ecnt++;
    if (wr) last_wr = ecnt;
    lk = ((ecnt - last_wr) >= 16);
    exp_q.push_back({1'b1, m_ce, lk, e_ce});
    @(posedge refclk);
    #3;
    cfg_we = 1'b0;
  endtask

  task automatic write_cfg(input logic [SEL_W-1:0] sel, input int num, input int den);
    cfg_we  = 1'b1;
    cfg_sel = sel;
    cfg_num = ACC_W'(num);
    cfg_den = ACC_W'(den);
  endtask

  task automatic check_now(input string name, input logic [4:0] got, input logic [4:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, got, req);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    cfg_we  = 1'b0;
    cfg_sel = '0;
    cfg_num = '0;
    cfg_den = '0;
    ch_run  = 4'b0001;
    #3;
    check_now("reset_hold", {locked, ce}, 5'b0);
    #9;
    rst_n = 1'b1;

    // defaults 1/6 on ch0, lock after 16 edges
    for (int k = 0; k < 36; k++) cyc({3'b0, ce0_nx()}, 4'hF, 1'b0);

    // ch1 = 2/5
    write_cfg(3'd1, 2, 5);
    ch_run = 4'b0011;
    cyc({3'b0, ce0_nx()}, 4'hF, 1'b1);
    j1  = 0;
    cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      j1++;
      cyc({2'b0, p25(j1), ce0_nx()}, 4'hF, 1'b0);
      cnt += int'(ce[1]);
    end
    check_int("ratio_2_5_pulses", cnt, 400);

    // out-of-range select must change nothing
    write_cfg(3'd5, 1, 1);
    for (int k = 0; k < 20; k++) begin
      j1++;
      cyc({2'b0, p25(j1), ce0_nx()}, 4'hF, 1'b0);
    end

    // ch2 = 357/3600: exact count over one period, never adjacent
    write_cfg(3'd2, 357, 3600);
    ch_run = 4'b0111;
    j1++;
    cyc({2'b0, p25(j1), ce0_nx()}, 4'hF, 1'b1);
    cnt  = 0;
    adj  = 0;
    prev = 1'b0;
    for (int k = 0; k < 3600; k++) begin
      j1++;
      cyc({2'b0, p25(j1), ce0_nx()}, 4'b1011, 1'b0);
      if (ce[2] && prev) adj++;
      prev = ce[2];
      cnt += int'(ce[2]);
    end
    check_int("ratio_357_3600_pulses", cnt, 357);
    check_int("ratio_357_3600_adjacent", adj, 0);

    // edge ratios: 7/7 and 9/4 held high, den=0 held low
    write_cfg(3'd2, 7, 7);
    ch_run = 4'b1111;
    j1++;
    cyc({2'b00, p25(j1), ce0_nx()}, 4'hF, 1'b1);
    write_cfg(3'd3, 9, 4);
    j1++;
    cyc({2'b01, p25(j1), ce0_nx()}, 4'hF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      j1++;
      cyc({2'b11, p25(j1), ce0_nx()}, 4'hF, 1'b0);
    end
    write_cfg(3'd3, 5, 0);
    j1++;
    cyc({2'b01, p25(j1), ce0_nx()}, 4'hF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      j1++;
      cyc({2'b01, p25(j1), ce0_nx()}, 4'hF, 1'b0);
    end

    // back-to-back writes to ch1: 1/3 must win over 1/2
    write_cfg(3'd1, 1, 2);
    cyc({3'b010, ce0_nx()}, 4'hF, 1'b1);
    write_cfg(3'd1, 1, 3);
    cyc({3'b010, ce0_nx()}, 4'hF, 1'b1);
    j1 = 0;
    for (int k = 0; k < 34; k++) begin
      j1++;
      cyc({2'b01, (j1 % 3) == 0, ce0_nx()}, 4'hF, 1'b0);
    end

    // drop ch1 mid-count (acc=1), then restart from a clean phase
    ch_run = 4'b1101;
    for (int k = 0; k < 3; k++) cyc({3'b010, ce0_nx()}, 4'hF, 1'b0);
    ch_run = 4'b1111;
    j1 = 0;
    for (int k = 0; k < 9; k++) begin
      j1++;
      cyc({2'b01, (j1 % 3) == 0, ce0_nx()}, 4'hF, 1'b0);
    end

    // asynchronous reset between edges, then defaults restored
    #3;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", {locked, ce}, 5'b0);
    @(negedge refclk);
    rst_n   = 1'b1;
    ecnt    = 0;
    last_wr = 0;
    for (int k = 0; k < 13; k++) cyc({4{ce0_nx()}}, 4'hF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
